// File: rtl/booth_mac_ctrl_pkg.sv
// Shared types and constant helpers for the Booth MAC controller.
package booth_mac_ctrl_pkg;

    // Controller sequencing: arbitrate, clear core, iterate, write back.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

    // Width needed to index n items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Radix-4 Booth retires two multiplier bits per iteration.
    function automatic int unsigned booth_count(input int unsigned data_width);
        return data_width / 2;
    endfunction

endpackage

// File: rtl/booth_mac_ctrl_if.sv
// Requester-side bus: per-lane operation requests and accumulator results.
interface booth_mac_ctrl_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            req_clr;
    logic [NUM_REQ*ACC_WIDTH-1:0]  acc_out;
    logic [NUM_REQ-1:0]            acc_valid;
    logic [NUM_REQ-1:0]            acc_ovf;

    // MAC lanes side.
    modport master (
        output req_valid, req_a, req_b, req_clr,
        input  req_ready, acc_out, acc_valid, acc_ovf
    );

    // Controller side.
    modport slave (
        input  req_valid, req_a, req_b, req_clr,
        output req_ready, acc_out, acc_valid, acc_ovf
    );
endinterface

// File: rtl/booth_mac_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module rr_arbiter
    import booth_mac_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    // Scan lanes cyclically starting at ptr; the first hit is granted.
    always_comb begin : scan
        int unsigned idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_any && req[IDX_W'(idx)]) begin
                gnt_any              = 1'b1;
                gnt_idx              = IDX_W'(idx);
                gnt[IDX_W'(idx)]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mac_ctrl.sv
// Time-shares one sequential radix-4 Booth core among NUM_REQ MAC lanes,
// each with its own signed accumulator and sticky overflow flag.
module booth_mac_ctrl
    import booth_mac_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_mac_ctrl_if.slave       bus,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    output logic                  mul_rst,
    input  logic [OUT_WIDTH-1:0]  mul_c,
    output logic                  busy
);

    localparam int unsigned COUNT  = booth_count(DATA_WIDTH);
    localparam int unsigned ITER_W = idx_width(COUNT);
    localparam int unsigned IDX_W  = idx_width(NUM_REQ);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic                   clr_q, clr_d;
    logic [ITER_W-1:0]      iter_cnt_q, iter_cnt_d;
    logic [DATA_WIDTH-1:0]  mul_a_q, mul_a_d;
    logic [DATA_WIDTH-1:0]  mul_b_q, mul_b_d;
    logic [ACC_WIDTH-1:0]   acc_q [NUM_REQ];
    logic [ACC_WIDTH-1:0]   acc_d [NUM_REQ];
    logic [NUM_REQ-1:0]     acc_ovf_q, acc_ovf_d;
    logic [NUM_REQ-1:0]     acc_valid_q, acc_valid_d;

    logic [DATA_WIDTH-1:0]  a_lane [NUM_REQ];
    logic [DATA_WIDTH-1:0]  b_lane [NUM_REQ];

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

    logic [ACC_WIDTH-1:0]   acc_base;
    logic                   ovf_base;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic                   add_ovf;

    // Unpack lane operands and pack accumulator results.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign a_lane[g] = bus.req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_lane[g] = bus.req_b[g*DATA_WIDTH +: DATA_WIDTH];
        assign bus.acc_out[g*ACC_WIDTH +: ACC_WIDTH] = acc_q[g];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Grants are offered only while idle; core is held in reset until RUN.
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE) ? arb_gnt : '0;
        bus.acc_valid = acc_valid_q;
        bus.acc_ovf   = acc_ovf_q;
        mul_a         = mul_a_q;
        mul_b         = mul_b_q;
        mul_rst       = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        busy          = (state_q != ST_IDLE);
    end

    // Signed accumulate of the sign-extended product into the granted lane.
    always_comb begin
        acc_base = clr_q ? '0 : acc_q[gnt_q];
        ovf_base = clr_q ? 1'b0 : acc_ovf_q[gnt_q];
        prod_ext = ACC_WIDTH'($signed(mul_c));
        acc_sum  = acc_base + prod_ext;
        add_ovf  = (acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                   (acc_sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
    end

    // Next-state and datapath update for the IDLE/LOAD/RUN/CAPTURE sequence.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        clr_d       = clr_q;
        iter_cnt_d  = iter_cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        acc_valid_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    mul_a_d  = a_lane[arb_idx];
                    mul_b_d  = b_lane[arb_idx];
                    clr_d    = bus.req_clr[arb_idx];
                    gnt_d    = arb_idx;
                    rr_ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                iter_cnt_d = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                iter_cnt_d = iter_cnt_q + 1'b1;
                if (iter_cnt_q == ITER_W'(COUNT - 1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                acc_d[gnt_q]       = acc_sum;
                acc_ovf_d[gnt_q]   = ovf_base | add_ovf;
                acc_valid_d[gnt_q] = 1'b1;
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, grant and accumulator registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            clr_q       <= 1'b0;
            iter_cnt_q  <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            acc_ovf_q   <= '0;
            acc_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            clr_q       <= clr_d;
            iter_cnt_q  <= iter_cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            acc_ovf_q   <= acc_ovf_d;
            acc_valid_q <= acc_valid_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Bench for booth_mac_ctrl: behavioural Booth core plus an arithmetic
// reference model of arbitration, latency and per-lane accumulation.
module tb_booth_mac_ctrl;

    localparam int DW    = 16;
    localparam int OW    = 32;
    localparam int AW    = 40;
    localparam int NR    = 4;
    localparam int COUNT = DW / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_mac_ctrl_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    logic [DW-1:0] mul_a, mul_b;
    logic          mul_rst;
    logic [OW-1:0] mul_c;
    logic          busy;

    booth_mac_ctrl #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .ACC_WIDTH  (AW),
        .NUM_REQ    (NR)
    ) dut (
        .clk     (clk),
        .rst     (rst_n),
        .bus     (bus),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_rst (mul_rst),
        .mul_c   (mul_c),
        .busy    (busy)
    );

    // Sequential radix-4 Booth core: sync active-high reset, COUNT iterations.
    logic [OW-1:0] core_c;
    int            core_i;

    function automatic logic [OW-1:0] booth_step(input logic [DW-1:0] a, input logic [DW-1:0] b, input int k);
        logic [DW:0] bx;
        logic [2:0]  t;
        int          d;
        int          p;
        bx = {b, 1'b0};
        t  = bx[2*k +: 3];
        case (t)
            3'b000, 3'b111: d = 0;
            3'b001, 3'b010: d = 1;
            3'b011:         d = 2;
            3'b100:         d = -2;
            default:        d = -1;
        endcase
        p = d * int'($signed(a));
        return OW'(p <<< (2 * k));
    endfunction

    always @(posedge clk) begin
        if (mul_rst) begin
            core_c <= '0;
            core_i <= 0;
        end else if (core_i < COUNT) begin
            core_c <= core_c + booth_step(mul_a, mul_b, core_i);
            core_i <= core_i + 1;
        end
    end
    assign mul_c = core_c;

    // Check bookkeeping.
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [NR*AW-1:0] got, input logic [NR*AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic [AW-1:0] m_acc [NR];
    logic [NR-1:0] m_ovf;
    int            m_ptr;
    bit            pend;
    int            p_lane;
    logic [DW-1:0] p_a, p_b;
    logic          p_clr;
    int            p_cyc;
    int            cyc = 0;
    int            hs_count = 0;
    int            done_count = 0;
    int            hs_lane_log[$];
    int            hs_cyc_log[$];

    localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (AW - 1));

    function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return NR'(1) << ((ptr + k) % NR);
        end
        return '0;
    endfunction

    function automatic logic [NR*AW-1:0] model_packed();
        logic [NR*AW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*AW +: AW] = m_acc[i];
        return r;
    endfunction

    logic [NR-1:0] exp_ready;
    longint        m_prod, m_base, m_sum;

    // Monitor on the falling edge: retire ops, check handshake and state.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_acc[i] = '0;
            m_ovf = '0;
            m_ptr = 0;
            pend  = 1'b0;
        end else begin
            if (bus.acc_valid != '0) begin
                if (!pend) begin
                    check_val("acc_valid_spurious", bus.acc_valid, '0);
                end else begin
                    check_val("acc_valid_lane", bus.acc_valid, NR'(1) << p_lane);
                    check_val("latency", cyc - p_cyc, COUNT + 3);
                    m_prod = longint'($signed(p_a)) * longint'($signed(p_b));
                    m_base = p_clr ? 64'sd0 : longint'($signed(m_acc[p_lane]));
                    m_sum  = m_base + m_prod;
                    m_acc[p_lane] = AW'(m_sum);
                    m_ovf[p_lane] = (p_clr ? 1'b0 : m_ovf[p_lane]) | ((m_sum > MAXV) || (m_sum < MINV));
                    pend = 1'b0;
                    done_count++;
                end
            end
            if (pend && (cyc - p_cyc > COUNT + 3)) begin
                check_val("op_timeout", cyc - p_cyc, COUNT + 3);
                pend = 1'b0;
            end
            check_val("acc_out", bus.acc_out, model_packed());
            check_val("acc_ovf", bus.acc_ovf, m_ovf);
            exp_ready = pend ? '0 : model_grant(bus.req_valid, m_ptr);
            check_val("req_ready", bus.req_ready, exp_ready);
            check_val("busy", busy, pend);
            if (pend) begin
                check_val("mul_a_hold", mul_a, p_a);
                check_val("mul_b_hold", mul_b, p_b);
            end
            if (exp_ready != '0) begin
                for (int i = 0; i < NR; i++) if (exp_ready[i]) p_lane = i;
                p_a   = bus.req_a[p_lane*DW +: DW];
                p_b   = bus.req_b[p_lane*DW +: DW];
                p_clr = bus.req_clr[p_lane];
                p_cyc = cyc;
                pend  = 1'b1;
                m_ptr = (p_lane + 1) % NR;
                hs_count++;
                hs_lane_log.push_back(p_lane);
                hs_cyc_log.push_back(cyc);
            end
        end
    end

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_lane(input int lane, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic clr);
        bus.req_a[lane*DW +: DW] = a;
        bus.req_b[lane*DW +: DW] = b;
        bus.req_clr[lane]        = clr;
    endtask

    task automatic wait_hs(input int h0);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            if (hs_count != h0) got = 1'b1;
        end
        #1 bus.req_valid = '0;
        if (!got) check_val("hs_timeout", hs_count, h0 + 1);
    endtask

    task automatic wait_done(input int d0, input int n);
        bit got = 1'b0;
        for (int k = 0; k < 20 * n + 20 && !got; k++) begin
            @(posedge clk);
            if (done_count >= d0 + n) got = 1'b1;
        end
        #1;
        if (!got) check_val("done_timeout", done_count, d0 + n);
    endtask

    task automatic do_op(input int lane, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic clr);
        int h0, d0;
        h0 = hs_count;
        d0 = done_count;
        set_lane(lane, a, b, clr);
        bus.req_valid       = '0;
        bus.req_valid[lane] = 1'b1;
        wait_hs(h0);
        wait_done(d0, 1);
    endtask

    function automatic logic [DW-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return DW'($urandom);
        endcase
    endfunction

    logic [AW-1:0] lane_val;
    int            h0, d0;

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_clr   = '0;
        apply_reset(3);

        // Reset state.
        @(negedge clk);
        check_val("rst_acc_out", bus.acc_out, '0);
        check_val("rst_ready", bus.req_ready, '0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_mul_rst", mul_rst, 1'b1);
        check_val("rst_acc_ovf", bus.acc_ovf, '0);

        // Clear with a negative product, then a large positive add.
        do_op(0, 16'd3, 16'hFFFB, 1'b1);
        @(negedge clk);
        lane_val = bus.acc_out[0 +: AW];
        check_val("acc0_neg15", lane_val, 40'hFFFFFFFFF1);
        check_val("acc_valid_pulse", bus.acc_valid, '0);
        do_op(0, 16'h8000, 16'h8000, 1'b0);
        @(negedge clk);
        lane_val = bus.acc_out[0 +: AW];
        check_val("acc0_2p30m15", lane_val, 40'h003FFFFFF1);
        check_val("acc0_ovf", bus.acc_ovf[0], 1'b0);

        // All lanes requesting continuously from a fresh round-robin pointer.
        apply_reset(2);
        hs_lane_log.delete();
        hs_cyc_log.delete();
        h0 = hs_count;
        d0 = done_count;
        for (int i = 0; i < NR; i++) set_lane(i, rand_operand(), rand_operand(), 1'($urandom));
        bus.req_valid = '1;
        for (int k = 0; k < 100 && hs_count < h0 + 5; k++) @(posedge clk);
        #1 bus.req_valid = '0;
        wait_done(d0, 5);
        check_val("rr_count", hs_lane_log.size(), 5);
        for (int i = 0; i < 5 && i < hs_lane_log.size(); i++) begin
            check_val("rr_lane", hs_lane_log[i], i % NR);
            if (i > 0) check_val("rr_interval", hs_cyc_log[i] - hs_cyc_log[i-1], COUNT + 3);
        end

        // Reset during the fifth RUN cycle of a lane-2 op aborts it.
        h0 = hs_count;
        set_lane(2, 16'h1234, 16'h0F0F, 1'b0);
        bus.req_valid    = '0;
        bus.req_valid[2] = 1'b1;
        wait_hs(h0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_val("abort_acc_out", bus.acc_out, '0);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_done", done_count, d0 + 5);
        do_op(2, 16'd7, 16'd6, 1'b0);
        @(negedge clk);
        lane_val = bus.acc_out[2*AW +: AW];
        check_val("acc2_42", lane_val, 40'd42);

        // Clear behaviour and sticky overflow on lane 1.
        do_op(1, 16'd40, 16'd25, 1'b1);
        @(negedge clk);
        lane_val = bus.acc_out[AW +: AW];
        check_val("acc1_1000", lane_val, 40'd1000);
        do_op(1, 16'd0, 16'd0, 1'b1);
        @(negedge clk);
        lane_val = bus.acc_out[AW +: AW];
        check_val("acc1_clr0", lane_val, 40'd0);
        do_op(1, 16'h8000, 16'h8000, 1'b1);
        for (int k = 0; k < 515; k++) do_op(1, 16'h8000, 16'h8000, 1'b0);
        @(negedge clk);
        check_val("acc1_ovf_set", bus.acc_ovf[1], 1'b1);
        do_op(1, 16'd0, 16'd0, 1'b1);
        @(negedge clk);
        lane_val = bus.acc_out[AW +: AW];
        check_val("acc1_clr_after_ovf", lane_val, 40'd0);
        check_val("acc1_ovf_cleared", bus.acc_ovf[1], 1'b0);

        // Randomized traffic: shifting request masks and operands.
        for (int it = 0; it < 250; it++) begin
            for (int i = 0; i < NR; i++) set_lane(i, rand_operand(), rand_operand(), ($urandom_range(0, 3) == 0));
            bus.req_valid = NR'($urandom);
            repeat ($urandom_range(1, 15)) @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        for (int k = 0; k < 30 && pend; k++) @(posedge clk);
        @(negedge clk);
        check_val("final_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop if the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
